dadda_mul_arbiter: RTL

//  Shares one combinational 8x8 unsigned Dadda multiplier (dadda_8) between NREQ requesters.
//  A round-robin arbiter grants one requester at a time and registers its operands.
//  The block then registers the 16-bit product and returns it on a single response channel,

---
 rtl/dadda_mul_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dadda_mul_arbiter.sv
// Round-robin arbiter sharing one 8x8 unsigned Dadda multiplier
// between NREQ requesters, with a single tagged response channel.

module dadda_8 (
   input  logic [7:0]  a_i,
   input  logic [7:0]  b_i,
   output logic [15:0] y_o
);
   logic [7:0]  col [16];
   logic [7:0]  nxt [16];
   logic [3:0]  n   [16];
   logic [3:0]  m   [16];
   logic [3:0]  d, h, p;
   logic        s, cy, x0, x1, x2;
   logic [15:0] r0, r1;

   // column compression: stage heights 6,4,3,2, then a final adder
   always_comb begin
      d  = 4'd6;
      h  = '0;
      p  = '0;
      s  = 1'b0;
      cy = 1'b0;
      x0 = 1'b0;
      x1 = 1'b0;
      x2 = 1'b0;
      r0 = '0;
      r1 = '0;
      for (int c = 0; c < 16; c++) begin
         col[c] = '0;
         nxt[c] = '0;
         n[c]   = '0;
         m[c]   = '0;
      end
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            col[i+j][n[i+j][2:0]] = a_i[i] & b_i[j];
            n[i+j] = n[i+j] + 4'd1;
         end
      end
      for (int st = 0; st < 4; st++) begin
         unique case (st)
            0:       d = 4'd6;
            1:       d = 4'd4;
            2:       d = 4'd3;
            default: d = 4'd2;
         endcase
         for (int c = 0; c < 16; c++) begin
            nxt[c] = '0;
            m[c]   = '0;
         end
         for (int c = 0; c < 16; c++) begin
            p = 4'd0;
            h = n[c] + m[c];
            for (int k = 0; k < 3; k++) begin
               if (h > d) begin
                  x0 = col[c][3'(p)];
                  x1 = col[c][3'(p + 4'd1)];
                  x2 = col[c][3'(p + 4'd2)];
                  if (h - d >= 4'd2) begin
                     s  = x0 ^ x1 ^ x2;
                     cy = (x0 & x1) | (x0 & x2) | (x1 & x2);
                     p  = p + 4'd3;
                     h  = h - 4'd2;
                  end else begin
                     s  = x0 ^ x1;
                     cy = x0 & x1;
                     p  = p + 4'd2;
                     h  = h - 4'd1;
                  end
                  nxt[c][m[c][2:0]] = s;
                  m[c] = m[c] + 4'd1;
                  if (c < 15) begin
                     nxt[c+1][m[c+1][2:0]] = cy;
                     m[c+1] = m[c+1] + 4'd1;
                  end
               end
            end
            for (int k = 0; k < 8; k++) begin
               if (4'(k) >= p && 4'(k) < n[c]) begin
                  nxt[c][m[c][2:0]] = col[c][k];
                  m[c] = m[c] + 4'd1;
               end
            end
         end
         for (int c = 0; c < 16; c++) begin
            col[c] = nxt[c];
            n[c]   = m[c];
         end
      end
      for (int c = 0; c < 16; c++) begin
         r0[c] = col[c][0];
         r1[c] = col[c][1];
      end
      y_o = r0 + r1;
   end
endmodule

module dadda_mul_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [8*NREQ-1:0] req_a,
   input  logic [8*NREQ-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [15:0]       rsp_y,
   output logic              busy,
   output logic [CNTW-1:0]   done_cnt
);
   typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  rr_q, rr_d;
   logic [IDW-1:0]  gid_q, gid_d;
   logic [7:0]      a_q, a_d, b_q, b_d;
   logic [15:0]     y_q, y_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            gnt_vld;
   logic [IDW-1:0]  gnt_id, cand;
   logic [15:0]     prod;

   dadda_8 u_mul (
      .a_i (a_q),
      .b_i (b_q),
      .y_o (prod)
   );

   // first valid requester at or after rr_q, wrapping upward
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      cand    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = IDW'((int'(rr_q) + k) % NREQ);
         if (req_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_id  = cand;
         end
      end
   end

   // next state, handshake and datapath updates
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      gid_d     = gid_q;
      a_d       = a_q;
      b_d       = b_q;
      y_d       = y_q;
      id_d      = id_q;
      cnt_d     = cnt_q;
      req_ready = '0;
      unique case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               req_ready[gnt_id] = 1'b1;
               a_d     = req_a[{gnt_id, 3'b000} +: 8];
               b_d     = req_b[{gnt_id, 3'b000} +: 8];
               gid_d   = gnt_id;
               rr_d    = IDW'((int'(gnt_id) + 1) % NREQ);
               state_d = MUL;
            end
         end
         MUL: begin
            y_d     = prod;
            id_d    = gid_q;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               cnt_d   = cnt_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= '0;
         gid_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         y_q     <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gid_q   <= gid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         y_q     <= y_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q == MUL) || (state_q == RESP);
   assign rsp_y     = y_q;
   assign rsp_id    = id_q;
   assign done_cnt  = cnt_q;
endmodule
